// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and helpers for the unrolled Ascon permutation.
// Optional feature macro used by the top: ASCON_PERM_ABSORB_EN.
package ascon_pkg;

  localparam int BW         = 64;
  localparam int NUM_WORDS  = 5;
  localparam int MAX_ROUNDS = 12;

  // Linear-layer rotation pair for each state word x0..x4
  localparam int ROT_A [NUM_WORDS] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [NUM_WORDS] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [NUM_WORDS-1:0][BW-1:0] ascon_state_t;

  function automatic logic [7:0] rc(input logic [3:0] i);
    return 8'd240 - ({4'd0, i} * 8'd15);
  endfunction

  function automatic logic [BW-1:0] ror(input logic [BW-1:0] x, input int n);
    return (x >> n) | (x << (BW - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round (constant, bitsliced S-box, linear layer).
// When active_i is low the state passes through untouched.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   rnd_i,
  input  logic         active_i,
  output ascon_state_t state_o
);

  ascon_state_t x;
  ascon_state_t t;
  ascon_state_t y;

  always_comb begin
    x = state_i;
    t = '0;
    y = '0;
    x[2] = x[2] ^ {{(BW-8){1'b0}}, rc(rnd_i)};
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int w = 0; w < NUM_WORDS; w++) begin
      t[w] = ~x[w] & x[(w + 1) % NUM_WORDS];
    end
    for (int w = 0; w < NUM_WORDS; w++) begin
      x[w] = x[w] ^ t[(w + 1) % NUM_WORDS];
    end
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    for (int w = 0; w < NUM_WORDS; w++) begin
      y[w] = x[w] ^ ror(x[w], ROT_A[w]) ^ ror(x[w], ROT_B[w]);
    end
    state_o = active_i ? y : state_i;
  end

endmodule

// File: rtl/ascon_perm_unrolled.sv
// Ascon permutation with runtime round count and UNROLL rounds per clock.
// `define ASCON_PERM_ABSORB_EN adds load_xor for XOR-absorb loads.
module ascon_perm_unrolled
  import ascon_pkg::*;
#(
  parameter int BW     = 64,
  parameter int UNROLL = 1,
  parameter int NR_W   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_en,
`ifdef ASCON_PERM_ABSORB_EN
  input  logic            load_xor,
`endif
  input  logic [2:0]      slice_idx,
  input  logic [BW-1:0]   slice_in,
  output logic [BW-1:0]   slice_out,
  input  logic            start,
  input  logic [NR_W-1:0] nr,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      round
);

  state_e       fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  ascon_state_t state_q, state_d;
  logic [BW-1:0] slice_out_q, slice_out_d;
  logic         err_q, err_d;
  ascon_state_t chain_out;
  logic         nr_ok;
  logic [4:0]   rnd_sum;

  // Stage k works on round rnd+k; stages past round 11 become bypasses.
  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    ascon_state_t s_in;
    ascon_state_t s_out;
    logic [4:0]   idx;
    if (k == 0) begin : g_first
      assign s_in = state_q;
    end else begin : g_next
      assign s_in = g_stage[k-1].s_out;
    end
    assign idx = {1'b0, rnd_q} + 5'(k);
    ascon_round u_round (
      .state_i  (s_in),
      .rnd_i    (idx[3:0]),
      .active_i (idx <= 5'd11),
      .state_o  (s_out)
    );
  end
  assign chain_out = g_stage[UNROLL-1].s_out;

  assign nr_ok   = (nr != '0) && (nr <= NR_W'(MAX_ROUNDS));
  assign rnd_sum = {1'b0, rnd_q} + 5'(UNROLL);

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    err_d       = 1'b0;
    slice_out_d = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (slice_idx == 3'(w)) slice_out_d = state_q[w];
    end
    case (fsm_q)
      ST_IDLE: begin
        if (load_en) begin
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (slice_idx == 3'(w)) begin
`ifdef ASCON_PERM_ABSORB_EN
              state_d[w] = load_xor ? (state_q[w] ^ slice_in) : slice_in;
`else
              state_d[w] = slice_in;
`endif
            end
          end
        end else if (start) begin
          if (nr_ok) begin
            rnd_d = 4'd12 - 4'(nr);
            fsm_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        state_d = chain_out;
        rnd_d   = rnd_sum[3:0];
        if (rnd_sum >= 5'd12) begin
          fsm_d = ST_DONE;
          rnd_d = 4'd0;
        end
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
        rnd_d = 4'd0;
      end
      default: begin
        fsm_d = ST_IDLE;
        rnd_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q       <= ST_IDLE;
      rnd_q       <= 4'd0;
      state_q     <= '0;
      slice_out_q <= '0;
      err_q       <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      slice_out_q <= slice_out_d;
      err_q       <= err_d;
    end
  end

  assign slice_out = slice_out_q;
  assign ready     = (fsm_q == ST_IDLE);
  assign busy      = (fsm_q == ST_RUN);
  assign done      = (fsm_q == ST_DONE);
  assign err       = err_q;
  assign round     = (fsm_q == ST_RUN) ? rnd_q : 4'd0;

endmodule

// File: tb/tb_ascon_perm_unrolled.sv
// Directed bench for ascon_perm_unrolled; runs UNROLL=1 and UNROLL=4 side by side
// against a table-driven Ascon reference model.
module tb_ascon_perm_unrolled;

  typedef logic [4:0][63:0] st_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic        clk = 1'b0;
  logic        rstn, load_en, start;
  logic [2:0]  slice_idx;
  logic [63:0] slice_in;
  logic [3:0]  nr;
`ifdef ASCON_PERM_ABSORB_EN
  logic        load_xor;
`endif
  logic [63:0] so1, so4;
  logic        rdy1, rdy4, bsy1, bsy4, dn1, dn4, er1, er4;
  logic [3:0]  rd1, rd4;

  int n_vec = 0;
  int n_mis = 0;
  st_t ms, iv;
  int dc1, dc4, nd1, nd4, bc1, bc4, ne1, ne4;
  logic [3:0] r1a, r1b, r4a, r4b;
  logic [63:0] a1, a4;

  always #5 clk = ~clk;

  ascon_perm_unrolled #(.BW(64), .UNROLL(1), .NR_W(4)) dut1 (
    .clk(clk), .rstn(rstn), .load_en(load_en),
`ifdef ASCON_PERM_ABSORB_EN
    .load_xor(load_xor),
`endif
    .slice_idx(slice_idx), .slice_in(slice_in), .slice_out(so1),
    .start(start), .nr(nr), .ready(rdy1), .busy(bsy1), .done(dn1),
    .err(er1), .round(rd1));

  ascon_perm_unrolled #(.BW(64), .UNROLL(4), .NR_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .load_en(load_en),
`ifdef ASCON_PERM_ABSORB_EN
    .load_xor(load_xor),
`endif
    .slice_idx(slice_idx), .slice_in(slice_in), .slice_out(so4),
    .start(start), .nr(nr), .ready(rdy4), .busy(bsy4), .done(dn4),
    .err(er4), .round(rd4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t m_round(input st_t s, input int i);
    st_t t;
    logic [4:0] c, o;
    s[2] = s[2] ^ 64'(240 - 15 * i);
    for (int b = 0; b < 64; b++) begin
      c = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o = SBOX[c];
      t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
    end
    s[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
    s[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
    s[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
    s[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
    s[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
    return s;
  endfunction

  function automatic st_t m_perm(input st_t s, input int n);
    for (int i = 12 - n; i < 12; i++) s = m_round(s, i);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [2:0] w, input logic [63:0] v);
    load_en = 1'b1; slice_idx = w; slice_in = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_all(input st_t s);
    for (int w = 0; w < 5; w++) load_word(3'(w), s[w]);
  endtask

  task automatic read_word(input logic [2:0] w, output logic [63:0] v1, output logic [63:0] v4);
    slice_idx = w;
    tick();
    v1 = so1; v4 = so4;
  endtask

  task automatic cmp_state(input string tag);
    logic [63:0] b1, b4;
    for (int w = 0; w < 5; w++) begin
      read_word(3'(w), b1, b4);
      chk($sformatf("%s_w%0d_u1", tag, w), b1, ms[w]);
      chk($sformatf("%s_w%0d_u4", tag, w), b4, ms[w]);
    end
  endtask

  task automatic run(input logic [3:0] n, input bit inject);
    dc1 = 0; dc4 = 0; nd1 = 0; nd4 = 0; bc1 = 0; bc4 = 0; ne1 = 0; ne4 = 0;
    r1a = 4'hf; r1b = 4'hf; r4a = 4'hf; r4b = 4'hf;
    start = 1'b1; nr = n;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (inject && (c == 3 || c == 4)) begin
        start = 1'b1; nr = 4'd12;
        load_en = 1'b1; slice_idx = 3'd0; slice_in = 64'hDEADBEEFCAFEF00D;
      end
      if (dn1) begin nd1++; dc1 = c; end
      if (dn4) begin nd4++; dc4 = c; end
      if (bsy1) bc1++;
      if (bsy4) bc4++;
      if (er1) ne1++;
      if (er4) ne4++;
      if (c == 1) begin r1a = rd1; r4a = rd4; end
      if (c == 2) begin r1b = rd1; r4b = rd4; end
      tick();
      start = 1'b0; load_en = 1'b0;
    end
  endtask

  initial begin
    rstn = 1'b0; load_en = 1'b0; start = 1'b0; nr = 4'd0;
    slice_idx = 3'd0; slice_in = 64'd0;
`ifdef ASCON_PERM_ABSORB_EN
    load_xor = 1'b0;
`endif
    #12;
    chk("rst_ready_u1", 64'(rdy1), 64'd1);
    chk("rst_ready_u4", 64'(rdy4), 64'd1);
    chk("rst_busy", 64'({bsy1, bsy4}), 64'd0);
    chk("rst_done", 64'({dn1, dn4}), 64'd0);
    chk("rst_err", 64'({er1, er4}), 64'd0);
    chk("rst_round", 64'({rd1, rd4}), 64'd0);
    chk("rst_sout", so1 | so4, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    iv[0] = 64'h80400c0600000000;
    iv[1] = 64'h0001020304050607;
    iv[2] = 64'h08090a0b0c0d0e0f;
    iv[3] = 64'h0f0e0d0c0b0a0908;
    iv[4] = 64'h0706050403020100;
    load_all(iv);
    ms = iv;

    read_word(3'd0, a1, a4);
    slice_idx = 3'd2;
    #1;
    chk("rd_hold_u1", so1, ms[0]);
    tick();
    chk("rd_lat_u1", so1, ms[2]);
    read_word(3'd5, a1, a4);
    chk("rd_idx5_u1", a1, 64'd0);
    chk("rd_idx5_u4", a4, 64'd0);
    load_word(3'd6, 64'hFFFFFFFFFFFFFFFF);
    cmp_state("load");

    run(4'd12, 1'b0);
    chk("p12_done_u1", 64'(dc1), 64'd13);
    chk("p12_done_u4", 64'(dc4), 64'd4);
    chk("p12_busy_u1", 64'(bc1), 64'd12);
    chk("p12_busy_u4", 64'(bc4), 64'd3);
    chk("p12_ndone", 64'(nd1 + nd4), 64'd2);
    chk("p12_rnd_u4", 64'({r4a, r4b}), 64'h04);
    ms = m_perm(iv, 12);
    cmp_state("p12");

    load_all(iv);
    run(4'd6, 1'b0);
    chk("p6_done_u1", 64'(dc1), 64'd7);
    chk("p6_done_u4", 64'(dc4), 64'd3);
    chk("p6_busy_u4", 64'(bc4), 64'd2);
    chk("p6_rnd_u4", 64'({r4a, r4b}), 64'h6A);
    chk("p6_rnd_u1", 64'({r1a, r1b}), 64'h67);
    ms = m_perm(iv, 6);
    cmp_state("p6");

    ms = '0;
    load_all(ms);
    run(4'd1, 1'b0);
    chk("p1_round_u1", 64'(r1a), 64'd11);
    chk("p1_round_u4", 64'(r4a), 64'd11);
    chk("p1_done_u1", 64'(dc1), 64'd2);
    chk("p1_done_u4", 64'(dc4), 64'd2);
    read_word(3'd0, a1, a4);
    chk("p1_x0_hand_u1", a1, 64'h000964B00000004B);
    chk("p1_x0_hand_u4", a4, 64'h000964B00000004B);
    read_word(3'd4, a1, a4);
    chk("p1_x4_hand_u1", a1, 64'd0);
    ms = m_perm(64'd0, 1);
    cmp_state("p1");

    for (int k = 0; k < 2; k++) begin
      start = 1'b1; nr = (k == 0) ? 4'd0 : 4'd13;
      tick();
      start = 1'b0;
      chk($sformatf("err_pulse_%0d", k), 64'({er1, er4}), 64'h3);
      chk($sformatf("err_ready_%0d", k), 64'({rdy1, rdy4}), 64'h3);
      chk($sformatf("err_busy_%0d", k), 64'({bsy1, bsy4}), 64'h0);
      tick();
      chk($sformatf("err_clear_%0d", k), 64'({er1, er4}), 64'h0);
      read_word(3'd0, a1, a4);
      chk($sformatf("err_state_%0d", k), a1, ms[0]);
    end

    load_en = 1'b1; start = 1'b1; nr = 4'd12; slice_idx = 3'd1; slice_in = 64'h1122334455667788;
    tick();
    load_en = 1'b0; start = 1'b0;
    ms[1] = 64'h1122334455667788;
    chk("ldst_err", 64'({er1, er4}), 64'h0);
    chk("ldst_busy", 64'({bsy1, bsy4}), 64'h0);
    read_word(3'd1, a1, a4);
    chk("ldst_val_u1", a1, ms[1]);
    chk("ldst_val_u4", a4, ms[1]);

    load_all(iv);
    run(4'd12, 1'b1);
    chk("inj_ndone_u1", 64'(nd1), 64'd1);
    chk("inj_ndone_u4", 64'(nd4), 64'd1);
    chk("inj_done_u1", 64'(dc1), 64'd13);
    chk("inj_err", 64'(ne1 + ne4), 64'd0);
    ms = m_perm(iv, 12);
    cmp_state("inj");

    start = 1'b1; nr = 4'd12;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("mid_busy_pre", 64'(bsy1), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_ready", 64'({rdy1, rdy4}), 64'h3);
    chk("mid_busy", 64'({bsy1, bsy4}), 64'h0);
    chk("mid_done", 64'({dn1, dn4}), 64'h0);
    chk("mid_round", 64'({rd1, rd4}), 64'h0);
    chk("mid_sout", so1 | so4, 64'd0);
    tick();
    rstn = 1'b1;
    nd1 = 0;
    for (int c = 0; c < 16; c++) begin
      if (dn1 || dn4 || bsy1 || bsy4) nd1++;
      tick();
    end
    chk("mid_no_done", 64'(nd1), 64'd0);
    ms = '0;
    cmp_state("mid");

`ifdef ASCON_PERM_ABSORB_EN
    load_word(3'd0, 64'hFFFF0000FFFF0000);
    load_xor = 1'b1;
    load_word(3'd0, 64'h0F0F0F0F0F0F0F0F);
    load_xor = 1'b0;
    read_word(3'd0, a1, a4);
    chk("absorb_u1", a1, 64'hF0F00F0FF0F00F0F);
    chk("absorb_u4", a4, 64'hF0F00F0FF0F00F0F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ascon_perm_unrolled.md
Name: ascon_perm_unrolled

Overview:
Parametrised successor to the single-round-per-cycle Ascon permutation core. It holds the 320-bit state as five 64-bit words, loaded and read one slice at a time. It runs a runtime-selectable number of rounds (pa=12, pb=6/8, or any 1..12), with a configurable number of rounds unrolled per clock, under a start/ready/done handshake. It sits between the AEAD/hash sponge controller and the state datapath.

Parameters:
BW, 64, word width per state slice (Ascon requires 64; kept for consistency with sibling cores)
UNROLL, 1, rounds computed per clock; legal values 1, 2, 3, 4, 6, 12
NR_W, 4, width of the round-count input

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
load_en  in  1  write slice_in into state[slice_idx]
slice_idx  in  3  slice select for load and read (0..4)
slice_in  in  BW  load data
slice_out  out  BW  registered read data of state[slice_idx]
start  in  1  request permutation run
nr  in  NR_W  number of rounds for this run, sampled with start (1..12)
ready  out  1  high in IDLE; start accepted only when high
busy  out  1  high while rounds execute
done  out  1  one-cycle pulse when the state holds the result
err  out  1  one-cycle pulse when start is rejected for an illegal nr
round  out  4  current round index (0..11) being applied; 0 when idle

Behaviour:
- Reset (rstn=0, asynchronous): state words=0, FSM=IDLE, rnd=0, slice_out=0, ready=1, busy=0, done=0, err=0. Reset mid-run aborts the run with no done pulse.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE, start=1, nr in 1..12, load_en=0: rnd <= 12-nr, go to RUN.
- IDLE, start=1, nr=0 or nr>12: err pulses next cycle; FSM stays in IDLE; state is unchanged.
- IDLE, load_en=1 and start=1 in the same cycle: the load is applied and start is dropped (no err).
- RUN: each cycle applies stages k=0..UNROLL-1 in cascade. Stage k uses round index rnd+k.
  - Stage k is active only when rnd+k<=11; otherwise it passes its input through unchanged.
  - Then rnd <= rnd+UNROLL.
  - When rnd+UNROLL>=12, the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: the done pulse occurs ceil(nr/UNROLL)+1 cycles after the start edge.
- Round function for index i:
  - Constant layer: x2 ^= (240 - 15*i), 8-bit, zero-extended.
  - S-box layer: bitsliced Ascon S-box.
  - Linear layer: x0 ^= ror19 ^ ror28; x1 ^= ror61 ^ ror39; x2 ^= ror1 ^ ror6; x3 ^= ror10 ^ ror17; x4 ^= ror7 ^ ror41.
- Rules while busy or in DONE:
  - load_en is ignored.
  - start is ignored, and err is not raised.
  - ready=0.
- slice_out is registered with one-cycle latency. slice_idx 5..7: read returns 0 and writes are ignored.
- busy=1 exactly in RUN. round=rnd in RUN and 0 otherwise.

Optional Feature:
Macro ASCON_PERM_ABSORB_EN.
- Defined: adds input port load_xor (1 bit). When load_en=1 and load_xor=1, the core performs state[slice_idx] <= state[slice_idx] ^ slice_in (sponge absorb). load_xor=0 gives a plain write.
- Undefined: the port is absent and every load is a plain write.

Decomposition:
- Package ascon_pkg holds:
  - constants BW=64, NUM_WORDS=5, MAX_ROUNDS=12
  - the rotation amount pairs per word
  - the FSM state encoding (IDLE/RUN/DONE)
  - the round-constant function rc(i)=240-15*i
- Sub-module ascon_round: one combinational round with inputs state (5xBW), rnd index and active bit, and output state. Instantiate it UNROLL times in a generate loop.

Test Plan:
- UNROLL=1: load 5 slices, then start with nr=12 → busy for 12 cycles, done 13 cycles after start, state matches the C model p12 output. Also: read slice 2 → value appears one cycle after slice_idx is set.
- UNROLL=4, nr=6 → rnd sequence 6, 10; stage 2–3 bypass in the second cycle; done at cycle 3; result equals the UNROLL=1 p6 result.
- UNROLL=1, nr=1 on the zero state → round shows 11 and the constant applied is 0x4B; one round, done at cycle 2; result matches the model.
- start with nr=0 and with nr=13 → err pulse, ready stays 1, state unchanged. Also: start during RUN → ignored, no second done.
- rstn low at RUN cycle 5 → all outputs at reset values immediately, state reads 0, no done.
- ASCON_PERM_ABSORB_EN: state[0]=0xFFFF0000FFFF0000, then load_xor with slice_in=0x0F0F0F0F0F0F0F0F → readback 0xF0F00F0FF0F00F0F.
